// File: rtl/hssi_bridge_arb_pkg.sv
// Shared types and the round-robin pick function for the HSSI bridge arbiter.
package hssi_bridge_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int PKT_CNT_WIDTH = 16;
    localparam int MAX_REQ       = 16;
    localparam int MAX_ID_WIDTH  = 4;

    typedef struct packed {
        logic                    found;
        logic [MAX_ID_WIDTH-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping at num_req. The loop runs
    // from the far end back toward ptr so the nearest candidate is written last.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]      valid,
                                         input logic [MAX_ID_WIDTH-1:0] ptr,
                                         input int                      num_req);
        rr_pick_t res;
        int       j;
        res = '{found: 1'b0, idx: '0};
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < num_req) begin
                j = int'(ptr) + k;
                if (j >= num_req) j = j - num_req;
                if (valid[j[3:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[MAX_ID_WIDTH-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hssi_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr.
module hssi_rr_pick
    import hssi_bridge_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                found,
    output logic [ID_WIDTH-1:0] idx
);

    rr_pick_t res;

    always_comb begin
        res = rr_pick(MAX_REQ'(valid), MAX_ID_WIDTH'(ptr), NUM_REQ);
    end

    assign found = res.found;
    assign idx   = ID_WIDTH'(res.idx);

endmodule

// File: rtl/hssi_bridge_rr_arbiter.sv
// Packet-aware round-robin arbiter feeding one registered bridge output stage.
// Define HSSI_BRIDGE_ARB_PKT_CNT_EN to add per-requester completed-packet counters.
module hssi_bridge_rr_arbiter
    import hssi_bridge_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_last,
    output logic [ID_WIDTH-1:0]           m_src_id,
    input  logic                          m_ready,
    output logic                          busy
`ifdef HSSI_BRIDGE_ARB_PKT_CNT_EN
    ,
    output logic [NUM_REQ*PKT_CNT_WIDTH-1:0] pkt_cnt
`endif
);

    arb_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic [ID_WIDTH-1:0]   m_src_id_q, m_src_id_d;

    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  load;
    logic                  accept;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    hssi_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .valid (s_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Output stage can take a beat when empty or being drained this cycle.
    assign load = ~m_valid_q | m_ready;

    // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_valid = s_valid[i];
                sel_last  = s_last[i];
                sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // s_ready is built only from registered state and m_ready, never from s_valid.
    always_comb begin
        s_ready = '0;
        if (state_q == ARB_LOCKED && load) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_q == ID_WIDTH'(i)) s_ready[i] = 1'b1;
            end
        end
    end

    assign accept = (state_q == ARB_LOCKED) & load & sel_valid;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (accept && sel_last) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                     : grant_q + ID_WIDTH'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        m_src_id_d = m_src_id_q;
        if (load) begin
            m_valid_d = accept;
            if (accept) begin
                m_data_d   = sel_data;
                m_last_d   = sel_last;
                m_src_id_d = grant_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            m_src_id_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            m_src_id_q <= m_src_id_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign m_src_id = m_src_id_q;
    assign busy     = (state_q == ARB_LOCKED);

`ifdef HSSI_BRIDGE_ARB_PKT_CNT_EN
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q [NUM_REQ];
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt_d [NUM_REQ];

    // Counters wrap naturally at their width.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pkt_cnt_d[i] = pkt_cnt_q[i];
            if (accept && sel_last && grant_q == ID_WIDTH'(i)) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + PKT_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) pkt_cnt_q[i] <= '0;
            else       pkt_cnt_q[i] <= pkt_cnt_d[i];
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign pkt_cnt[g*PKT_CNT_WIDTH +: PKT_CNT_WIDTH] = pkt_cnt_q[g];
    end
`endif

endmodule
